// File: rtl/fetch_controller_pkg.sv
// Shared encodings for the fetch controller and the IF stage datapath.
// States, select codes and the control bundle that drives IF.
package fetch_controller_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fstate_t;

   localparam logic PC_SEL_SEQ   = 1'b0;
   localparam logic PC_SEL_BR    = 1'b1;
   localparam logic HOLD_SEL_MEM = 1'b0;
   localparam logic HOLD_SEL_BUF = 1'b1;

   typedef struct packed {
      logic memreq;
      logic pcwrite;
      logic pcsel;
      logic ifidwrite;
      logic ifidflush;
      logic holdload;
      logic holdsel;
      logic instvalid;
   } fctl_t;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Saturating wait counter for outstanding memory requests.
// expired pulses on the cycle the count reaches TIMEOUT_CYCLES.
module fetch_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LIM = W'(TIMEOUT_CYCLES);
   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && cnt != LIM) begin
         cnt <= cnt + ONE;
      end
   end

   assign expired = en && !clr && (cnt == LIM - ONE);

endmodule

// File: rtl/fetch_controller.sv
// IF stage sequencer: PC load, memory handshake, IF/ID write/hold/flush.
// Arbitrates memory completion, ID hazard stalls and EX branches.
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazardStall,
   input  logic             brTaken,
   input  logic             memReady,
   output logic             memReq,
   output logic             pcWrite,
   output logic             pcSel,
   output logic             ifIdWrite,
   output logic             ifIdFlush,
   output logic             holdLoad,
   output logic             holdSel,
   output logic             instValid,
   output logic             memTimeout,
   output logic [CNT_W-1:0] fetchCount
);

   fstate_t state, state_n;
   logic    discard, discard_n;
   fctl_t   ctl;
   logic    expired;
   logic    delivered;

   logic go_br, mem_take, mem_stall;
   logic mem_drop, hold_go;

   // Branch outranks everything, so the others are gated by it.
   assign go_br     = brTaken;
   assign mem_drop  = !brTaken && memReady && discard;
   assign mem_take  = !brTaken && memReady && !discard
                      && !hazardStall;
   assign mem_stall = !brTaken && memReady && !discard
                      && hazardStall;
   assign hold_go   = !brTaken && !hazardStall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= BOOT;
         discard <= 1'b0;
      end else begin
         state   <= state_n;
         discard <= discard_n;
      end
   end

   always_comb begin
      state_n   = state;
      discard_n = discard;
      unique case (state)
         BOOT: state_n = FETCH;
         FETCH: begin
            unique case (1'b1)
               go_br:     discard_n = !memReady;
               mem_drop:  discard_n = 1'b0;
               mem_stall: state_n   = HOLD;
               default: ;
            endcase
         end
         HOLD: begin
            if (go_br || hold_go) state_n = FETCH;
         end
         default: state_n = BOOT;
      endcase
   end

   always_comb begin
      ctl = '0;
      unique case (state)
         FETCH: begin
            ctl.memreq = 1'b1;
            unique case (1'b1)
               go_br: begin
                  ctl.pcwrite   = 1'b1;
                  ctl.pcsel     = PC_SEL_BR;
                  ctl.ifidflush = 1'b1;
               end
               mem_take: begin
                  ctl.pcwrite   = 1'b1;
                  ctl.pcsel     = PC_SEL_SEQ;
                  ctl.ifidwrite = 1'b1;
                  ctl.instvalid = 1'b1;
               end
               mem_stall: ctl.holdload = 1'b1;
               default: ;
            endcase
         end
         HOLD: begin
            ctl.holdsel = HOLD_SEL_BUF;
            unique case (1'b1)
               go_br: begin
                  ctl.pcwrite   = 1'b1;
                  ctl.pcsel     = PC_SEL_BR;
                  ctl.ifidflush = 1'b1;
               end
               hold_go: begin
                  ctl.pcwrite   = 1'b1;
                  ctl.pcsel     = PC_SEL_SEQ;
                  ctl.ifidwrite = 1'b1;
                  ctl.instvalid = 1'b1;
               end
               default: ;
            endcase
         end
         default: ctl.holdsel = HOLD_SEL_MEM;
      endcase
   end

   assign memReq    = ctl.memreq;
   assign pcWrite   = ctl.pcwrite;
   assign pcSel     = ctl.pcsel;
   assign ifIdWrite = ctl.ifidwrite;
   assign ifIdFlush = ctl.ifidflush;
   assign holdLoad  = ctl.holdload;
   assign holdSel   = ctl.holdsel;
   assign instValid = ctl.instvalid;

   assign delivered = ctl.ifidwrite && ctl.instvalid;

   fetch_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .en      ((state == FETCH) && !memReady),
      .clr     (memReady),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         memTimeout <= 1'b0;
         fetchCount <= '0;
      end else begin
         if (expired) memTimeout <= 1'b1;
         if (delivered) fetchCount <= fetchCount + CNT_W'(1);
      end
   end

endmodule
